// File: rtl/formation_march_ctrl.sv
// -----------------------------------------------------------------------------
// formation_march_ctrl
//   Sequences the alien formation march. Decides when the block steps
//   horizontally, when it reaches a side and must descend one row, and reports
//   wave-clear and invasion events to game-level control.
//
//   Optional feature macro: FORMATION_SPEEDUP_EN
//     defined   : step period = MIN_PERIOD + (alive_count >> 1), re-latched at
//                 wave start and on every step, so the march speeds up as
//                 aliens die
//     undefined : step period is the constant BASE_PERIOD
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   frame_tick          one-cycle pulse per video frame
//   start               one-cycle pulse, begins a wave (from IDLE or INVADED)
//   pause               level, freezes stepping and the frame counter
//   alive_count [7:0]   live aliens; zero while marching ends the wave
//   left_edge  [15:0]   x of leftmost live alien pixel (offset applied)
//   right_edge [15:0]   x of rightmost live alien pixel (offset applied)
//   bottom_edge[15:0]   y of lowest live alien pixel (offset applied)
//   offset_x   [15:0]   signed global x offset
//   offset_y   [15:0]   unsigned global y offset
//   movement_direction  1 = right, 0 = left
//   step_pulse          one cycle per horizontal step
//   descend_pulse       one cycle per descend
//   wave_clear          one cycle when the formation is wiped out
//   invaded             sticky until reset or start
//   busy                high while in MARCH or DESCEND
// -----------------------------------------------------------------------------
module formation_march_ctrl #(
    parameter int unsigned STEP_X      = 4,
    parameter int unsigned STEP_Y      = 16,
    parameter int unsigned MIN_X       = 8,
    parameter int unsigned MAX_X       = 632,
    parameter int unsigned INVADE_Y    = 400,
    parameter int unsigned BASE_PERIOD = 60,
    parameter int unsigned MIN_PERIOD  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        pause,
    input  logic [7:0]  alive_count,
    input  logic [15:0] left_edge,
    input  logic [15:0] right_edge,
    input  logic [15:0] bottom_edge,
    output logic [15:0] offset_x,
    output logic [15:0] offset_y,
    output logic        movement_direction,
    output logic        step_pulse,
    output logic        descend_pulse,
    output logic        wave_clear,
    output logic        invaded,
    output logic        busy
);

    localparam int unsigned POS_W = 16;
    localparam int unsigned CMP_W = POS_W + 1;
    localparam int unsigned CNT_W = 9;
    localparam int unsigned BASE_CLAMPED =
        (BASE_PERIOD < MIN_PERIOD) ? MIN_PERIOD : BASE_PERIOD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARCH   = 2'd1,
        DESCEND = 2'd2,
        INVADED = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [POS_W-1:0]   offset_x_q, offset_x_d;
    logic [POS_W-1:0]   offset_y_q, offset_y_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;
    logic               descend_q, descend_d;
    logic               wave_clear_q, wave_clear_d;
    logic               invaded_q, invaded_d;
    logic               busy_q, busy_d;

    logic               tick_ok;
    logic               step_due;
    logic               empty;
    logic               hit_right;
    logic               hit_left;
    logic               hit_edge;
    logic               will_invade;
    logic [CNT_W-1:0]   period_calc;

    // Edge tests widened by one bit so the additions cannot wrap.
    assign hit_right   = ({1'b0, right_edge} + CMP_W'(STEP_X)) > CMP_W'(MAX_X);
    assign hit_left    = {1'b0, left_edge} < CMP_W'(MIN_X + STEP_X);
    assign hit_edge    = dir_q ? hit_right : hit_left;
    assign will_invade = ({1'b0, bottom_edge} + CMP_W'(STEP_Y)) >= CMP_W'(INVADE_Y);

    assign empty    = (alive_count == 8'd0);
    assign tick_ok  = frame_tick & ~pause;
    assign step_due = tick_ok && (cnt_q >= (period_q - CNT_W'(1)));

    // Step period applied from the next step onward.
`ifdef FORMATION_SPEEDUP_EN
    logic [CNT_W-1:0] period_raw;
    assign period_raw  = CNT_W'(MIN_PERIOD) + CNT_W'(alive_count >> 1);
    assign period_calc = (period_raw < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD)
                                                            : period_raw;
`else
    assign period_calc = CNT_W'(BASE_CLAMPED);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; wave clear outranks any step or descend.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, INVADED: begin
                if (start) begin
                    state_d = MARCH;
                end
            end
            MARCH: begin
                if (empty) begin
                    state_d = IDLE;
                end else if (step_due && hit_edge) begin
                    state_d = DESCEND;
                end
            end
            DESCEND: begin
                if (empty) begin
                    state_d = IDLE;
                end else if (will_invade) begin
                    state_d = INVADED;
                end else begin
                    state_d = MARCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values, registered below.
    always_comb begin
        cnt_d        = cnt_q;
        period_d     = period_q;
        offset_x_d   = offset_x_q;
        offset_y_d   = offset_y_q;
        dir_d        = dir_q;
        invaded_d    = invaded_q;
        step_d       = 1'b0;
        descend_d    = 1'b0;
        wave_clear_d = 1'b0;
        busy_d       = (state_d == MARCH) || (state_d == DESCEND);

        unique case (state_q)
            IDLE, INVADED: begin
                if (start) begin
                    cnt_d      = '0;
                    period_d   = period_calc;
                    offset_x_d = '0;
                    offset_y_d = '0;
                    dir_d      = 1'b1;
                    invaded_d  = 1'b0;
                end
            end
            MARCH: begin
                if (empty) begin
                    wave_clear_d = 1'b1;
                end else if (tick_ok) begin
                    if (!step_due) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d    = '0;
                        period_d = period_calc;
                        if (!hit_edge) begin
                            step_d     = 1'b1;
                            offset_x_d = dir_q ? (offset_x_q + POS_W'(STEP_X))
                                               : (offset_x_q - POS_W'(STEP_X));
                        end
                    end
                end
            end
            DESCEND: begin
                if (empty) begin
                    wave_clear_d = 1'b1;
                end else begin
                    descend_d  = 1'b1;
                    offset_y_d = offset_y_q + POS_W'(STEP_Y);
                    dir_d      = ~dir_q;
                    if (will_invade) begin
                        invaded_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            period_q     <= CNT_W'(BASE_CLAMPED);
            offset_x_q   <= '0;
            offset_y_q   <= '0;
            dir_q        <= 1'b1;
            step_q       <= 1'b0;
            descend_q    <= 1'b0;
            wave_clear_q <= 1'b0;
            invaded_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            offset_x_q   <= offset_x_d;
            offset_y_q   <= offset_y_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            descend_q    <= descend_d;
            wave_clear_q <= wave_clear_d;
            invaded_q    <= invaded_d;
            busy_q       <= busy_d;
        end
    end

    assign offset_x           = offset_x_q;
    assign offset_y           = offset_y_q;
    assign movement_direction = dir_q;
    assign step_pulse         = step_q;
    assign descend_pulse      = descend_q;
    assign wave_clear         = wave_clear_q;
    assign invaded            = invaded_q;
    assign busy               = busy_q;

endmodule
